// File: rtl/shutdown_pkg.sv
// Shared state encoding and helpers for the power shutdown sequencer.
// Optional abort-from-WARN behaviour is enabled by SHUTDOWN_ABORT_EN (see shutdown_fsm).
package shutdown_pkg;

  localparam logic [1:0] RUN_CODE      = 2'd0;
  localparam logic [1:0] DEBOUNCE_CODE = 2'd1;
  localparam logic [1:0] WARN_CODE     = 2'd2;
  localparam logic [1:0] OFF_CODE      = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN      = RUN_CODE,
    ST_DEBOUNCE = DEBOUNCE_CODE,
    ST_WARN     = WARN_CODE,
    ST_OFF      = OFF_CODE
  } sd_state_e;

  // Counter must reach max(a,b)-1 without wrapping.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sd_timer.sv
// Shared cycle counter for DEBOUNCE and WARN: clear, saturating increment,
// and terminal-count compare against a caller-selected last value.
module sd_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] last_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != last_i)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == last_i);

endmodule

// File: rtl/shutdown_fsm.sv
// Power shutdown sequencer: debounced request -> host warning -> power off.
// Define SHUTDOWN_ABORT_EN to let a dropped request in WARN abort back to RUN.
//
// state    | meaning
// RUN      | powered, idle, waiting for req_sync
// DEBOUNCE | req_sync seen, counting consecutive high samples
// WARN     | warn_irq raised, waiting for host_ack or grace expiry
// OFF      | power removed; terminal until reset
module shutdown_fsm
  import shutdown_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GRACE_CYCLES    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_sync,
  input  logic       host_ack,
  output logic       pwr_en,
  output logic       warn_irq,
  output logic       shutdown_done,
  output logic       timeout,
  output logic [1:0] state_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, GRACE_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GR_LAST = CNT_W'(GRACE_CYCLES - 1);

  sd_state_e        state_q, state_d;
  logic             pwr_en_q, warn_q, done_q, timeout_q, timeout_d;
  logic             tmr_clr, tmr_inc, tmr_tc;
  logic [CNT_W-1:0] tmr_last;

  assign tmr_last = (state_q == ST_WARN) ? GR_LAST : DB_LAST;

  sd_timer #(.W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tmr_clr),
    .inc_i  (tmr_inc),
    .last_i (tmr_last),
    .tc_o   (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (req_sync) begin
          state_d = ST_DEBOUNCE;
          tmr_clr = 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (!req_sync) begin
          state_d = ST_RUN;
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          state_d = ST_WARN;
          tmr_clr = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_WARN: begin
        // host_ack wins over both abort and grace expiry
        if (host_ack) begin
          state_d = ST_OFF;
          tmr_clr = 1'b1;
        end
`ifdef SHUTDOWN_ABORT_EN
        else if (!req_sync) begin
          state_d = ST_RUN;
          tmr_clr = 1'b1;
        end
`endif
        else if (tmr_tc) begin
          state_d   = ST_OFF;
          timeout_d = 1'b1;
          tmr_clr   = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_OFF: begin
        timeout_d = timeout_q;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pwr_en_q  <= 1'b1;
      warn_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwr_en_q  <= (state_d != ST_OFF);
      warn_q    <= (state_d == ST_WARN);
      done_q    <= (state_d == ST_OFF);
      timeout_q <= timeout_d;
    end
  end

  assign pwr_en        = pwr_en_q;
  assign warn_irq      = warn_q;
  assign shutdown_done = done_q;
  assign timeout       = timeout_q;
  assign state_o       = state_q;

endmodule
